reg_file_mp: RTL and testbench
==============================

// Module: reg_file_mp
// PURPOSE
//  Parametrised multi-port integer register file with a per-register busy scoreboard for the RISC-V core.
//  Sits between decode (reads, allocation of destination regs) and writeback (NWR retire ports).
//  Successor of the single-write, two-read file. Adds N read ports, M write ports,
//  pending-write tracking with hazard flags, and optional same-cycle write->read bypass.
// PARAMETERS
//  XLEN   32  data width
//  NREGS  32  architectural registers, power of two; reg 0 hardwired to zero
//  NRD    2   read ports (1..4)
//  NWR    2   write ports (1..2); higher index has higher priority
// PORTS
//  clk        in   1            clock, rising edge
//  rstn       in   1            asynchronous active-low reset
//  wr_en      in   NWR          per-port write enable
//  wr_addr    in   NWR*AW       flattened write addresses, AW=$clog2(NREGS)
//  wr_data    in   NWR*XLEN     flattened write data
//  rd_en      in   NRD          per-port read enable
//  rd_addr    in   NRD*AW       flattened read addresses
//  rd_data    out  NRD*XLEN     read data; 0 when rd_en low
//  rd_busy    out  NRD          read source has a pending writer (hazard)
//  alloc_en   in   1            mark alloc_addr busy (dest issued by decode)
//  alloc_addr in   AW           register to mark busy
//  busy_cnt   out  AW+1         number of registers currently busy
//  flush      in   1            clear all busy bits (pipeline flush); data untouched
// BEHAVIOUR
//  - Reset (rstn low, any time, including mid-write): all regs=0, busy vector=0, busy_cnt=0.
//    rd_data/rd_busy are combinational: 0 while in reset.
//  - Write: on posedge, wr_en[k] && wr_addr[k]!=0 stores wr_data[k]. Visible on rd_data the next cycle.
//    Writes to reg 0 are dropped.
//  - Same-address writes on two ports in one cycle: port NWR-1 wins. Not an error.
//  - Read: rd_data[p] = rd_en[p] ? regs[rd_addr[p]] : 0. Reg 0 always reads 0.
//  - Scoreboard, per cycle, in priority order:
//    1. flush: next busy = 0, and any same-cycle alloc is ignored.
//    2. Else a write clears busy[wr_addr]; alloc_en sets busy[alloc_addr].
//    3. Alloc and write to the same reg in the same cycle: alloc wins (busy stays 1, new producer).
//  - alloc_addr=0 never sets busy; busy[0] is constant 0.
//  - Alloc to an already-busy reg keeps it busy and does not change the count.
//  - Write to a non-busy reg leaves busy at 0.
//  - rd_busy[p] = rd_en[p] && busy[rd_addr[p]] (registered busy state only).
//  - busy_cnt is a registered counter equal to popcount(busy) after every edge; it never wraps.
//    Range 0..NREGS-1. Update by ±delta, not by recomputing popcount.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - A read that matches an enabled, non-zero wr_addr in the same cycle returns that wr_data
//      (highest-priority port).
//    - rd_busy is suppressed for that port unless alloc_en targets the same reg that cycle.
//    - Read latency after write: 0 cycles.
//  REGFILE_BYPASS_EN undefined:
//    - Reads return stored contents only; a write is visible 1 cycle later.
//    - rd_busy reflects the registered busy bit.
// STRUCTURE
//  - Shared package rv_pkg: XLEN, NREGS, REG_AW localparams, and ZERO_REG constant.
//  - Sub-module rf_scoreboard: busy vector, flush/alloc/clear priority, busy_cnt counter.
//  - Storage array and read muxes/bypass stay in reg_file_mp.
// TESTING
//  1. Reset then read x1..x31 on all ports -> every rd_data=0, rd_busy=0, busy_cnt=0.
//  2. wr_en[0], x5<=0xDEADBEEF; same cycle read x5 -> old value 0 (no bypass) or 0xDEADBEEF (bypass);
//     next cycle -> 0xDEADBEEF.
//  3. Both ports write x7: port0 0x1111, port1 0x2222 -> x7=0x2222. Write x0=0xFFFF -> x0 still reads 0.
//  4. Alloc x3, then x4 -> busy_cnt=2, rd_busy on x3. Next cycle: write x3 plus alloc x3 -> x3 still busy, busy_cnt=2.
//     Then write x4 -> busy_cnt=1.
//  5. Alloc x9 with flush asserted the same cycle -> busy_cnt=0, x9 not busy.
//     Assert rstn low mid-write of x9 -> x9=0.
//  6. Random alloc/write/flush for 10k cycles: busy_cnt == popcount(model busy), data matches reference model.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared integer-register-file constants for the RISC-V core.
// Revision: 1.0
`default_nettype none

package rv_pkg;
    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int REG_AW = $clog2(NREGS);
    localparam logic [REG_AW-1:0] ZERO_REG = '0;
endpackage

`default_nettype wire

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: flush/alloc/clear priority plus a running busy count.
// Revision: 1.0
`default_nettype none

module rf_scoreboard #(
    parameter int NREGS = 32,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              flush,
    input  logic              alloc_en,
    input  logic [AW-1:0]     alloc_addr,
    output logic [NREGS-1:0]  busy,
    output logic [AW:0]       busy_cnt
);
    import rv_pkg::*;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);
    localparam logic [AW:0]   ONE       = (AW+1)'(1);

    logic              alloc_ok;
    logic [NREGS-1:0]  busy_nxt;
    logic [AW:0]       inc;
    logic [AW:0]       dec;
    logic [AW:0]       cnt_nxt;

    always_comb begin
        logic [AW-1:0] addr;
        logic          dup;
        alloc_ok = alloc_en && (alloc_addr != ZERO_ADDR);
        busy_nxt = busy;
        inc      = '0;
        dec      = '0;
        addr     = '0;
        dup      = 1'b0;
        for (int k = 0; k < NWR; k++) begin
            addr = wr_addr[k*AW +: AW];
            if (wr_en[k] && (addr != ZERO_ADDR)) begin
                busy_nxt[addr] = 1'b0;
                // A register hit by several write ports is only counted once (by the top port).
                dup = 1'b0;
                for (int j = k + 1; j < NWR; j++) begin
                    if (wr_en[j] && (wr_addr[j*AW +: AW] == addr)) begin
                        dup = 1'b1;
                    end
                end
                if (busy[addr] && !dup && !(alloc_ok && (alloc_addr == addr))) begin
                    dec = dec + ONE;
                end
            end
        end
        if (alloc_ok) begin
            if (!busy[alloc_addr]) begin
                inc = ONE;
            end
            busy_nxt[alloc_addr] = 1'b1;
        end
        if (flush) begin
            busy_nxt = '0;
        end
        cnt_nxt = flush ? '0 : (busy_cnt + inc - dec);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy     <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with busy scoreboard and hazard flags.
// Optional same-cycle write->read bypass when REGFILE_BYPASS_EN is defined. Revision: 1.0
`default_nettype none

module reg_file_mp #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic [NRD-1:0]      rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                alloc_en,
    input  logic [AW-1:0]       alloc_addr,
    output logic [AW:0]         busy_cnt,
    input  logic                flush
);
    import rv_pkg::*;

    localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    rf_scoreboard #(
        .NREGS (NREGS),
        .NWR   (NWR),
        .AW    (AW)
    ) u_scoreboard (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .flush      (flush),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy       (busy),
        .busy_cnt   (busy_cnt)
    );

    // Ports are visited in ascending order so the highest port wins an address collision.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != ZERO_ADDR)) begin
                    regs[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = rd_addr[p*AW +: AW];

        always_comb begin
            data = (addr == ZERO_ADDR) ? '0 : regs[addr];
            bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (addr != ZERO_ADDR) && (wr_addr[k*AW +: AW] == addr)) begin
                    data = wr_data[k*XLEN +: XLEN];
                    // The forwarded value resolves the hazard unless a new producer claims the reg.
                    if (!(alloc_en && (alloc_addr == addr))) begin
                        bsy = 1'b0;
                    end
                end
            end
`endif
        end

        assign rd_data[p*XLEN +: XLEN] = (rstn && rd_en[p]) ? data : '0;
        assign rd_busy[p]              = rstn && rd_en[p] && bsy;
    end

endmodule

`default_nettype wire

// File: tb/tb_reg_file_mp.sv
// Directed and model-checked random bench for reg_file_mp.
// Revision: 1.0
`default_nettype none

module tb_reg_file_mp;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                clk = 1'b0;
    logic                rstn;
    logic [NWR-1:0]      wr_en;
    logic [NWR*AW-1:0]   wr_addr;
    logic [NWR*XLEN-1:0] wr_data;
    logic [NRD-1:0]      rd_en;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                alloc_en;
    logic [AW-1:0]       alloc_addr;
    logic [AW:0]         busy_cnt;
    logic                flush;

    int checks   = 0;
    int failures = 0;

    logic [XLEN-1:0] regs_m [NREGS];
    bit              busy_m [NREGS];

    reg_file_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NRD   (NRD),
        .NWR   (NWR)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .rd_busy    (rd_busy),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .busy_cnt   (busy_cnt),
        .flush      (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = '0; rd_addr = '0;
        alloc_en = 1'b0; alloc_addr = '0; flush = 1'b0;
    endtask

    task automatic set_wr(input int k, input int addr, input logic [XLEN-1:0] data);
        wr_en[k] = 1'b1;
        wr_addr[k*AW +: AW] = AW'(addr);
        wr_data[k*XLEN +: XLEN] = data;
    endtask

    task automatic set_rd(input int p, input int addr);
        rd_en[p] = 1'b1;
        rd_addr[p*AW +: AW] = AW'(addr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [XLEN-1:0] rdd(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        rstn = 1'b0;
        set_rd(0, 5);
        #12;
        check("reset_rd_data", {32'h0, rdd(0)}, 64'h0);
        check("reset_busy_cnt", {58'h0, busy_cnt}, 64'h0);
        tick();
        rstn = 1'b1;
        tick();

        // 1. Every register reads zero and idle after reset
        for (int a = 1; a < NREGS; a++) begin
            idle();
            set_rd(0, a);
            set_rd(1, a);
            #1;
            check("post_reset_rd", {rdd(1), rdd(0)}, 64'h0);
            check("post_reset_busy", {62'h0, rd_busy}, 64'h0);
        end
        check("post_reset_cnt", {58'h0, busy_cnt}, 64'h0);

        // 2. Write latency
        idle();
        set_wr(0, 5, 32'hDEADBEEF);
        set_rd(0, 5);
        #1;
`ifdef REGFILE_BYPASS_EN
        check("same_cycle_rd_x5", {32'h0, rdd(0)}, 64'hDEADBEEF);
`else
        check("same_cycle_rd_x5", {32'h0, rdd(0)}, 64'h0);
`endif
        tick();
        idle();
        set_rd(0, 5);
        #1;
        check("next_cycle_rd_x5", {32'h0, rdd(0)}, 64'hDEADBEEF);
        rd_en = '0;
        set_rd(1, 5);
        rd_en[1] = 1'b0;
        #1;
        check("rd_en_low_zero", {32'h0, rdd(1)}, 64'h0);

        // 3. Port priority and x0 write drop
        idle();
        set_wr(0, 7, 32'h1111);
        set_wr(1, 7, 32'h2222);
        tick();
        idle();
        set_wr(1, 0, 32'hFFFF);
        set_rd(0, 7);
        set_rd(1, 0);
        #1;
        check("x7_port1_wins", {32'h0, rdd(0)}, 64'h2222);
        tick();
        idle();
        set_rd(1, 0);
        #1;
        check("x0_reads_zero", {32'h0, rdd(1)}, 64'h0);

        // 4. Scoreboard alloc/clear
        idle(); alloc_en = 1'b1; alloc_addr = 5'd3; tick();
        idle(); alloc_en = 1'b1; alloc_addr = 5'd4; tick();
        idle(); set_rd(0, 3); set_rd(1, 4); #1;
        check("cnt_after_2_alloc", {58'h0, busy_cnt}, 64'd2);
        check("busy_x3_x4", {62'h0, rd_busy}, 64'b11);
        idle(); set_wr(0, 3, 32'h33); alloc_en = 1'b1; alloc_addr = 5'd3; tick();
        idle(); set_rd(0, 3); #1;
        check("alloc_wins_cnt", {58'h0, busy_cnt}, 64'd2);
        check("alloc_wins_busy", {62'h0, rd_busy}, 64'b01);
        idle(); set_wr(1, 4, 32'h44); tick();
        idle(); set_rd(1, 4); #1;
        check("clear_x4_cnt", {58'h0, busy_cnt}, 64'd1);
        check("clear_x4_busy", {62'h0, rd_busy}, 64'b00);
        idle(); alloc_en = 1'b1; alloc_addr = 5'd3; tick();
        check("realloc_cnt", {58'h0, busy_cnt}, 64'd1);
        idle(); alloc_en = 1'b1; alloc_addr = 5'd0; tick();
        idle(); set_rd(0, 0); #1;
        check("alloc_x0_cnt", {58'h0, busy_cnt}, 64'd1);
        check("alloc_x0_busy", {62'h0, rd_busy}, 64'b00);
        idle(); set_wr(0, 10, 32'hA); tick();
        check("wr_nonbusy_cnt", {58'h0, busy_cnt}, 64'd1);
        idle(); set_wr(0, 3, 32'h1); set_wr(1, 3, 32'h2); tick();
        check("dual_wr_clear_cnt", {58'h0, busy_cnt}, 64'd0);

        // 5. Flush beats alloc; asynchronous reset mid-write
        idle(); alloc_en = 1'b1; alloc_addr = 5'd11; tick();
        idle(); flush = 1'b1; alloc_en = 1'b1; alloc_addr = 5'd9; tick();
        idle(); set_rd(0, 9); set_rd(1, 11); #1;
        check("flush_cnt", {58'h0, busy_cnt}, 64'd0);
        check("flush_busy", {62'h0, rd_busy}, 64'b00);
        idle(); set_wr(0, 9, 32'hAAAA); alloc_en = 1'b1; alloc_addr = 5'd12; tick();
        idle(); set_rd(0, 9); #1;
        check("x9_written", {32'h0, rdd(0)}, 64'hAAAA);
        check("cnt_before_reset", {58'h0, busy_cnt}, 64'd1);
        set_wr(0, 9, 32'h5555);
        #1;
        rstn = 1'b0;
        #1;
        check("x9_in_reset", {32'h0, rdd(0)}, 64'h0);
        check("cnt_in_reset", {58'h0, busy_cnt}, 64'd0);
        tick();
        idle();
        #2;
        rstn = 1'b1;
        set_rd(0, 9); set_rd(1, 7);
        #1;
        check("x9_after_reset", {rdd(1), rdd(0)}, 64'h0);
        tick();

        // 6. Random traffic against a reference model
        for (int i = 0; i < NREGS; i++) begin
            regs_m[i] = '0;
            busy_m[i] = 1'b0;
        end
        for (int cyc = 0; cyc < 10000; cyc++) begin
            logic [XLEN-1:0] exp_d [NRD];
            logic [NRD-1:0]  exp_b;
            int              pc;
            idle();
            for (int k = 0; k < NWR; k++) begin
                wr_en[k] = 1'($urandom_range(0, 1));
                wr_addr[k*AW +: AW] = AW'($urandom_range(0, 7));
                wr_data[k*XLEN +: XLEN] = $urandom;
            end
            for (int p = 0; p < NRD; p++) begin
                rd_en[p] = ($urandom_range(0, 3) != 0);
                rd_addr[p*AW +: AW] = AW'($urandom_range(0, 9));
            end
            alloc_en = 1'($urandom_range(0, 1));
            alloc_addr = AW'($urandom_range(0, 8));
            flush = ($urandom_range(0, 31) == 0);
            #1;
            for (int p = 0; p < NRD; p++) begin
                int a;
                a = int'(rd_addr[p*AW +: AW]);
                exp_d[p] = (a == 0) ? '0 : regs_m[a];
                exp_b[p] = busy_m[a];
`ifdef REGFILE_BYPASS_EN
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k] && a != 0 && int'(wr_addr[k*AW +: AW]) == a) begin
                        exp_d[p] = wr_data[k*XLEN +: XLEN];
                        if (!(alloc_en && int'(alloc_addr) == a)) exp_b[p] = 1'b0;
                    end
                end
`endif
                if (!rd_en[p]) begin
                    exp_d[p] = '0;
                    exp_b[p] = 1'b0;
                end
                check("rnd_rd_data", {32'h0, rdd(p)}, {32'h0, exp_d[p]});
            end
            check("rnd_rd_busy", {62'h0, rd_busy}, {62'h0, exp_b});
            pc = 0;
            for (int r = 0; r < NREGS; r++) pc += int'(busy_m[r]);
            check("rnd_busy_cnt", {58'h0, busy_cnt}, 64'(pc));
            for (int k = 0; k < NWR; k++) begin
                int a;
                a = int'(wr_addr[k*AW +: AW]);
                if (wr_en[k] && a != 0) begin
                    regs_m[a] = wr_data[k*XLEN +: XLEN];
                    busy_m[a] = 1'b0;
                end
            end
            if (alloc_en && alloc_addr != 0) busy_m[alloc_addr] = 1'b1;
            if (flush) begin
                for (int r = 0; r < NREGS; r++) busy_m[r] = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
